// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg: control-word bit indices, opcodes and strobe helper for the SAP sequencer
package control_sequencer_pkg;
    localparam int HLT = 0, MI = 1, RI = 2, RO = 3, IO = 4, II = 5, AI = 6, AO = 7;
    localparam int EO = 8, SU = 9, BI = 10, OI = 11, CE = 12, CO = 13, J = 14, FI = 15;
    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
        OP_STA = 4'h4, OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7,
        OP_JZ  = 4'h8, OP_OUT = 4'hE, OP_HLT = 4'hF
    } opcode_e;
    function automatic logic [15:0] sb(input int b);
        return 16'(1) << b;
    endfunction
endpackage

// File: rtl/control_sequencer_microstep_counter.sv
// microstep_counter: T-state counter with synchronous clear, restart-to-zero and hold
module microstep_counter (
    input  logic       clk,
    input  logic       clear,
    input  logic       restart,
    input  logic       hold,
    output logic [2:0] step
);
    always_ff @(posedge clk)
        step <= clear ? 3'd0 : hold ? step : restart ? 3'd0 : step + 3'd1;
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: T-state tracking and combinational microcode decode for the 4-bit SAP CPU
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int NUM_STEPS = 5
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [3:0]  opcode,
    input  logic        flag_carry,
    input  logic        flag_zero,
    output logic [15:0] ctrl_word,
    output logic [2:0]  step,
    output logic        halted,
    output logic        pc_enable,
    output logic        pc_jump_n,
    output logic        pc_bus_enable_n
);
    logic [15:0] dec;
    logic [2:0]  last;
    logic        hlt_now;
    // Hold must include the HLT T2 edge itself so step freezes at 2 as halted rises.
    assign hlt_now = !halted && step == 3'd2 && opcode == OP_HLT;
    assign last = (opcode == OP_ADD || opcode == OP_SUB) ? 3'(NUM_STEPS - 1) :
                  (opcode == OP_LDA || opcode == OP_STA) ? 3'd3 : 3'd2;
    microstep_counter u_cnt (
        .clk     (clk),
        .clear   (clear),
        .restart (step == last),
        .hold    (halted || hlt_now),
        .step    (step)
    );
    always_ff @(posedge clk)
        halted <= clear ? 1'b0 : halted || hlt_now;
    always_comb begin
        dec = '0;
        casez ({opcode, step})
            7'b????000: dec = sb(CO) | sb(MI);
            7'b????001: dec = sb(RO) | sb(II) | sb(CE);
            {OP_LDA, 3'd2}, {OP_ADD, 3'd2}, {OP_SUB, 3'd2}, {OP_STA, 3'd2}:
                dec = sb(IO) | sb(MI);
            {OP_LDA, 3'd3}: dec = sb(RO) | sb(AI);
            {OP_ADD, 3'd3}, {OP_SUB, 3'd3}: dec = sb(RO) | sb(BI);
            {OP_ADD, 3'd4}: dec = sb(EO) | sb(AI) | sb(FI);
            {OP_SUB, 3'd4}: dec = sb(EO) | sb(SU) | sb(AI) | sb(FI);
            {OP_STA, 3'd3}: dec = sb(AO) | sb(RI);
            {OP_LDI, 3'd2}: dec = sb(IO) | sb(AI);
            {OP_JMP, 3'd2}: dec = sb(IO) | sb(J);
            {OP_JC, 3'd2}:  dec = flag_carry ? sb(IO) | sb(J) : '0;
            {OP_JZ, 3'd2}:  dec = flag_zero ? sb(IO) | sb(J) : '0;
            {OP_OUT, 3'd2}: dec = sb(AO) | sb(OI);
            {OP_HLT, 3'd2}: dec = sb(HLT);
            default:        dec = '0;
        endcase
    end
    assign ctrl_word       = clear ? '0 : halted ? sb(HLT) : dec;
    assign pc_enable       = ctrl_word[CE];
    assign pc_jump_n       = ~ctrl_word[J];
    assign pc_bus_enable_n = ~ctrl_word[CO];
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized scoreboard bench against a per-instruction microcode reference
module tb_control_sequencer;
    typedef struct {
        logic [15:0] w;
        logic [2:0]  s;
        logic        h;
        bit          cs;
    } exp_t;
    typedef logic [15:0] wq_t[$];

    logic        clk = 0;
    logic        clear, flag_carry, flag_zero;
    logic [3:0]  opcode;
    logic [15:0] ctrl_word;
    logic [2:0]  step;
    logic        halted, pc_enable, pc_jump_n, pc_bus_enable_n;
    exp_t        q[$];
    exp_t        me;
    int          checks = 0, passes = 0;

    control_sequencer dut (
        .clk(clk), .clear(clear), .opcode(opcode), .flag_carry(flag_carry),
        .flag_zero(flag_zero), .ctrl_word(ctrl_word), .step(step), .halted(halted),
        .pc_enable(pc_enable), .pc_jump_n(pc_jump_n), .pc_bus_enable_n(pc_bus_enable_n)
    );

    always #5 clk = ~clk;

    // Whole-instruction strobe sequence, one word per cycle, straight from the microcode table.
    function automatic wq_t model(logic [3:0] op, logic c, logic z);
        wq_t s;
        s = '{16'h2002, 16'h1028};
        case (op)
            4'h1: begin s.push_back(16'h0012); s.push_back(16'h0048); end
            4'h2: begin s.push_back(16'h0012); s.push_back(16'h0408); s.push_back(16'h8140); end
            4'h3: begin s.push_back(16'h0012); s.push_back(16'h0408); s.push_back(16'h8340); end
            4'h4: begin s.push_back(16'h0012); s.push_back(16'h0084); end
            4'h5: s.push_back(16'h0050);
            4'h6: s.push_back(16'h4010);
            4'h7: s.push_back(c ? 16'h4010 : 16'h0000);
            4'h8: s.push_back(z ? 16'h4010 : 16'h0000);
            4'hE: s.push_back(16'h0880);
            4'hF: s.push_back(16'h0001);
            default: s.push_back(16'h0000);
        endcase
        return s;
    endfunction

    task automatic chk(string n, logic [15:0] act, logic [15:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s actual=%h required=%h (t=%0t)", n, act, req, $time);
    endtask

    task automatic cyc(logic clr, logic [3:0] op, logic c, logic z, exp_t e);
        clear = clr; opcode = op; flag_carry = c; flag_zero = z;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    // Opcode and flags are garbage during fetch; the real opcode appears from T2 on.
    task automatic run_instr(logic [3:0] op, logic c, logic z, int upto = 99);
        wq_t s;
        s = model(op, c, z);
        for (int k = 0; k < s.size() && k <= upto; k++)
            cyc(1'b0, k < 2 ? 4'($urandom) : op, k < 2 ? 1'($urandom) : c,
                k < 2 ? 1'($urandom) : z, '{s[k], 3'(k), 1'b0, 1'b1});
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            me = q.pop_front();
            chk("ctrl_word", ctrl_word, me.w);
            chk("pc_ctrl", {13'd0, pc_enable, pc_jump_n, pc_bus_enable_n},
                {13'd0, me.w[12], ~me.w[14], ~me.w[13]});
            if (me.cs) begin
                chk("step", {13'd0, step}, {13'd0, me.s});
                chk("halted", {15'd0, halted}, {15'd0, me.h});
            end
        end
    end

    initial begin
        clear = 1; opcode = 0; flag_carry = 0; flag_zero = 0;
        @(posedge clk); #1;
        cyc(1'b1, 4'h2, 1'b1, 1'b1, '{16'h0000, 3'd0, 1'b0, 1'b1});
        run_instr(4'h2, 1'b0, 1'b0);
        run_instr(4'h7, 1'b0, 1'b1);
        run_instr(4'h7, 1'b1, 1'b0);
        run_instr(4'h8, 1'b0, 1'b1);
        run_instr(4'h8, 1'b1, 1'b0);
        run_instr(4'h1, 1'b0, 1'b0);
        run_instr(4'h4, 1'b0, 1'b0);
        run_instr(4'h3, 1'b1, 1'b0);
        run_instr(4'hA, 1'b1, 1'b1);
        run_instr(4'h0, 1'b1, 1'b1);
        run_instr(4'hF, 1'b0, 1'b0);
        repeat (20) cyc(1'b0, 4'($urandom), 1'($urandom), 1'($urandom), '{16'h0001, 3'd2, 1'b1, 1'b1});
        cyc(1'b1, 4'hF, 1'b0, 1'b0, '{16'h0000, 3'd2, 1'b1, 1'b1});
        run_instr(4'hE, 1'b0, 1'b0);
        run_instr(4'h2, 1'b0, 1'b0, 2);
        cyc(1'b1, 4'h2, 1'b0, 1'b0, '{16'h0000, 3'd3, 1'b0, 1'b1});
        cyc(1'b1, 4'h2, 1'b0, 1'b0, '{16'h0000, 3'd0, 1'b0, 1'b1});
        run_instr(4'h5, 1'b0, 1'b0);
        for (int i = 0; i < 80; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 14));
            if ($urandom_range(0, 9) == 0) begin
                run_instr(op, 1'($urandom), 1'($urandom), $urandom_range(0, 1));
                cyc(1'b1, op, 1'b0, 1'b0, '{16'h0000, 3'd0, 1'b0, 1'b0});
            end else
                run_instr(op, 1'($urandom), 1'($urandom));
        end
        run_instr(4'h6, 1'b0, 1'b0);
        @(negedge clk); #1;
        chk("drain", 16'(q.size()), 16'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
